// File: rtl/multiplier_controller.sv
// ---------------------------------------------------------------------------
// multiplier_controller
//   Sequencer for an N-bit shift-and-add multiplier datapath. It takes an
//   operand pair over a valid/ready input handshake and latches it. It then
//   issues one do_init strobe and N do_shift strobes. Completion is offered
//   over a valid/ready output handshake, and the datapath is left untouched
//   until the result is taken.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both high. in_ready and out_valid are pure
//   decodes of state and inputs. A producer may change its payload only
//   after a transfer edge.
//
// Ports
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   in_valid         operand pair offered
//   in_ready         controller accepts an operand pair this cycle
//   in_multiplicand  multiplicand operand (N bits)
//   in_multiplier    multiplier operand (N bits)
//   out_valid        datapath product holds a finished result
//   out_ready        consumer accepts the result
//   flush            synchronous abort of any operation in progress
//   do_init          datapath strobe: a<=0, q<=dp_multiplier
//   do_shift         datapath strobe: one add-and-shift step
//   dp_multiplicand  latched multiplicand (N bits)
//   dp_multiplier    latched multiplier (N bits)
//   busy             state is INIT or SHIFT
//   dbg_state        current FSM state (0 IDLE, 1 INIT, 2 SHIFT, 3 DONE)
// ---------------------------------------------------------------------------
module multiplier_controller #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_multiplicand,
  input  logic [N-1:0] in_multiplier,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         flush,
  output logic         do_init,
  output logic         do_shift,
  output logic [N-1:0] dp_multiplicand,
  output logic [N-1:0] dp_multiplier,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  mcand_q, mplier_q;
  logic          accept;

  // A result in DONE can hand over to the next operand in the same edge,
  // so DONE with out_ready counts as a free slot.
  assign in_ready = ~flush & ((state_q == S_IDLE) |
                              ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_INIT;
      end
      S_INIT: begin
        count_d = CNT_LOAD;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // The count==0 cycle is itself the N-th shift.
        if (count_q != '0) count_d = count_q - CW'(1);
        else               state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = accept ? S_INIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides every transition; accept is already masked by flush.
    if (flush) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Operand registers load only on an accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept) begin
      mcand_q  <= in_multiplicand;
      mplier_q <= in_multiplier;
    end
  end

  assign do_init         = (state_q == S_INIT);
  assign do_shift        = (state_q == S_SHIFT);
  assign out_valid       = (state_q == S_DONE);
  assign busy            = (state_q == S_INIT) | (state_q == S_SHIFT);
  assign dp_multiplicand = mcand_q;
  assign dp_multiplier   = mplier_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_multiplier_controller.sv
// ---------------------------------------------------------------------------
// tb_multiplier_controller
//   Directed bench for multiplier_controller with N=4. A behavioural
//   shift-and-add datapath is driven by the controller strobes so that the
//   product can be compared against hand-computed values held in exp_q.
//   Inputs change #1 after a rising edge and outputs are sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_multiplier_controller;
  localparam int N = 4;

  logic         clock, reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, flush;
  logic [N-1:0] in_multiplicand, in_multiplier;
  logic         do_init, do_shift, busy;
  logic [N-1:0] dp_multiplicand, dp_multiplier;
  logic [1:0]   dbg_state;

  multiplier_controller #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .do_init(do_init), .do_shift(do_shift),
    .dp_multiplicand(dp_multiplicand), .dp_multiplier(dp_multiplier),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- datapath model ----------------
  logic [N-1:0] a_q, q_q;
  logic [N:0]   sum;
  logic [2*N-1:0] product;
  assign sum     = {1'b0, a_q} + (q_q[0] ? {1'b0, dp_multiplicand} : '0);
  assign product = {a_q, q_q};

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      q_q <= '0;
    end else if (do_init) begin
      a_q <= '0;
      q_q <= dp_multiplier;
    end else if (do_shift) begin
      a_q <= sum[N:1];
      q_q <= {sum[0], q_q[N-1:1]};
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [2*N-1:0] exp_q[$];
  int init_cnt = 0, shift_cnt = 0, ov_rise = 0, res_cnt = 0;
  logic ov_prev = 1'b0;

  always @(negedge clock) begin
    if (reset_n) begin
      chk("strobe_exclusive", {31'd0, do_init & do_shift}, 32'd0);
      if (do_init)  init_cnt++;
      if (do_shift) shift_cnt++;
      if (out_valid && !ov_prev) ov_rise++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          res_cnt++;
          chk("product", {24'd0, product}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    ov_prev = out_valid;
  end

  // ---------------- driver tasks ----------------
  // Offers an operand pair and returns #1 after the accept edge (cycle 1).
  task automatic send(input logic [N-1:0] mc, input logic [N-1:0] mp);
    bit ok = 0;
    @(posedge clock); #1;
    in_multiplicand = mc;
    in_multiplier   = mp;
    in_valid        = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Counts falling edges until out_valid is seen; returns that count.
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (out_valid) begin k = i; break; end
    end
    if (k == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic advance(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // ---------------- stimulus ----------------
  int k, t1, t2, ov_before;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_multiplicand = '0; in_multiplier = '0;
    #23;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_do_init",   {31'd0, do_init},   32'd0);
    chk("rst_do_shift",  {31'd0, do_shift},  32'd0);
    chk("rst_dp_mcand",  {28'd0, dp_multiplicand}, 32'd0);
    chk("rst_dp_mplier", {28'd0, dp_multiplier},   32'd0);
    chk("rst_state",     {30'd0, dbg_state}, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // 1: 3x5, latency and strobe counts
    send(4'd3, 4'd5);
    exp_q.push_back(8'h0F);
    init_cnt = 0; shift_cnt = 0;
    wait_done(k);
    chk("t1_latency",   k, 32'd6);
    chk("t1_init_cnt",  init_cnt, 32'd1);
    chk("t1_shift_cnt", shift_cnt, 32'd4);

    // 2: 15x15 held in DONE for 5 cycles
    @(posedge clock); #1; out_ready = 1'b0;
    send(4'd15, 4'd15);
    exp_q.push_back(8'hE1);
    wait_done(k);
    chk("t2_latency", k, 32'd6);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid",   {31'd0, out_valid}, 32'd1);
      chk("t2_hold_product", {24'd0, product},   32'hE1);
      chk("t2_hold_ready",   {31'd0, in_ready},  32'd0);
      @(negedge clock);
    end
    @(posedge clock); #1; out_ready = 1'b1;
    @(negedge clock);
    chk("t2_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_accept_ready", {31'd0, in_ready},  32'd1);
    @(negedge clock);
    chk("t2_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_idle_state", {30'd0, dbg_state}, 32'd0);

    // 3: back-to-back 3x5 then 7x9, in_valid held high
    @(posedge clock); #1;
    in_multiplicand = 4'd3; in_multiplier = 4'd5; in_valid = 1'b1;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h3F);
    @(negedge clock);
    chk("t3_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_multiplicand = 4'd7; in_multiplier = 4'd9;
    wait_done(k);
    chk("t3_latency1", k, 32'd6);
    t1 = cyc;
    chk("t3_ready_done", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1; in_valid = 1'b0;
    @(negedge clock);
    chk("t3_direct_init", {31'd0, do_init}, 32'd1);
    chk("t3_dp_mcand",    {28'd0, dp_multiplicand}, 32'd7);
    wait_done(k);
    t2 = cyc;
    chk("t3_spacing", t2 - t1, 32'd6);

    // 4: flush in the 2nd SHIFT cycle
    send(4'd9, 4'd9);            // now in cycle 1 (INIT)
    ov_before = ov_rise;
    advance(2);                  // cycle 3 = 2nd SHIFT
    flush = 1'b1;
    @(negedge clock);
    chk("t4_shift_during", {31'd0, do_shift}, 32'd1);
    chk("t4_ready_flush",  {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1; flush = 1'b0;
    @(negedge clock);
    chk("t4_shift_after", {31'd0, do_shift}, 32'd0);
    chk("t4_busy_after",  {31'd0, busy},     32'd0);
    chk("t4_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t4_dp_kept",     {28'd0, dp_multiplier}, 32'd9);
    advance(8);
    chk("t4_no_result", ov_rise - ov_before, 32'd0);
    send(4'd2, 4'd6);
    exp_q.push_back(8'h0C);
    wait_done(k);
    chk("t4_latency", k, 32'd6);

    // 5: asynchronous reset mid-SHIFT
    send(4'd9, 4'd9);
    advance(2);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("t5_do_shift", {31'd0, do_shift},  32'd0);
    chk("t5_do_init",  {31'd0, do_init},   32'd0);
    chk("t5_out_valid",{31'd0, out_valid}, 32'd0);
    chk("t5_busy",     {31'd0, busy},      32'd0);
    chk("t5_dp_clear", {28'd0, dp_multiplicand}, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    send(4'd4, 4'd4);
    exp_q.push_back(8'h10);
    wait_done(k);
    chk("t5_latency", k, 32'd6);

    // 6: operand churn while busy, in_valid kept high
    send(4'd11, 4'd13);
    exp_q.push_back(8'h8F);
    in_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid) begin in_valid = 1'b0; k = 1; break; end
      chk("t6_dp_mcand",  {28'd0, dp_multiplicand}, 32'd11);
      chk("t6_dp_mplier", {28'd0, dp_multiplier},   32'd13);
      @(posedge clock); #1;
      in_multiplicand = 4'(i * 5 + 1);
      in_multiplier   = 4'(i * 3 + 2);
    end
    chk("t6_done_seen", k, 32'd1);
    advance(3);

    chk("results_seen", res_cnt, 32'd7);
    chk("queue_empty",  exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/multiplier_controller.md
Name: multiplier_controller

Overview:
Sequencer for the N-bit shift-and-add multiplier datapath. It accepts operand pairs over a valid/ready input handshake and latches them. It then drives the datapath's do_init and do_shift strobes for exactly one init cycle and N shift cycles. It presents completion over a valid/ready output handshake and holds the datapath product stable until the result is accepted.

Parameters:
N, 4, datapath width in bits; legal range N >= 2; must match the datapath instance's N.
CW, $clog2(N), shift counter width; derived, not overridden.

Ports:
clock  input  1  rising-edge system clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  controller can accept an operand pair this cycle
in_multiplicand  input  N  multiplicand operand
in_multiplier  input  N  multiplier operand
out_valid  output  1  datapath product holds a finished result
out_ready  input  1  consumer accepts the result
flush  input  1  synchronous abort of any operation in progress
do_init  output  1  datapath strobe: a<=0, q<=dp_multiplier
do_shift  output  1  datapath strobe: one add-and-shift step
dp_multiplicand  output  N  latched multiplicand, wired to the datapath
dp_multiplier  output  N  latched multiplier, wired to the datapath
busy  output  1  state is INIT or SHIFT

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, count=0, dp_multiplicand=0, dp_multiplier=0.
  - Consequently do_init=0, do_shift=0, out_valid=0, busy=0, in_ready=1.
- States: IDLE, INIT, SHIFT, DONE. All outputs except the dp_* registers are decoded combinationally from state.
  - do_init=1 only in INIT.
  - do_shift=1 only in SHIFT.
  - out_valid=1 only in DONE.
  - Never assert do_init and do_shift together.
- Accept: accept = in_valid & in_ready & ~flush.
  - in_ready = ~flush & (IDLE | (DONE & out_ready)).
  - On an accept edge, latch in_multiplicand and in_multiplier into dp_multiplicand and dp_multiplier, then go to INIT.
- INIT (1 cycle): load count=N-1, go to SHIFT.
- SHIFT (N cycles):
  - If count != 0, decrement.
  - If count == 0, go to DONE.
  - Exactly N do_shift cycles per operation.
- DONE:
  - Hold until out_ready.
  - out_ready & accept -> INIT (back-to-back).
  - out_ready & ~accept -> IDLE.
  - ~out_ready -> stay in DONE. The datapath is not strobed, so product is stable.
- Latency: with the accept edge at cycle 0, INIT occupies cycle 1, SHIFT occupies cycles 2..N+1, and out_valid rises in cycle N+2. Peak throughput is one result per N+2 cycles.
- dp_* registers change only on an accept edge. Input operand changes while busy or in DONE are ignored.
- Flush (highest priority after reset):
  - State goes to IDLE next edge and count goes to 0.
  - dp_* registers are unchanged and no strobes are issued.
  - A flush in DONE discards the result (out_valid drops).
  - A flush in the same cycle as in_valid accepts nothing.
- Reset mid-operation: immediate return to IDLE; no further strobes. The datapath is reset by the same reset_n.
- The controller never inspects product. Arithmetic width and carry handling belong to the datapath.

Test Plan:
1. N=4, after reset, offer 3x5 with out_ready=1 -> do_init for exactly 1 cycle, do_shift for exactly 4 cycles, out_valid at cycle 6 after accept, product=8'h0F.
2. 15x15 with out_ready=0 for 5 cycles after out_valid -> out_valid held, product stable at 8'hE1, in_ready=0; result accepted on the cycle out_ready=1, then controller returns to IDLE.
3. Back-to-back 3x5 then 7x9, in_valid held high, out_ready=1 -> second accept in DONE, direct DONE->INIT; results 8'h0F then 8'h3F; 6-cycle spacing between out_valid pulses.
4. flush in the 2nd SHIFT cycle -> do_shift drops next cycle, out_valid never asserts, in_ready=1; a following 2x6 gives 8'h0C correctly.
5. reset_n low asynchronously mid-SHIFT -> all strobes and out_valid go 0 immediately; after release, 4x4 gives 8'h10.
6. Change in_multiplicand/in_multiplier every cycle while busy -> dp_* outputs unchanged; result matches the operands latched at accept.
